writeback_stage: RTL and testbench

- Final pipeline stage; the write side of the register file that Decode reads.
- Captures the MEM/WB bundle and waits for load data through a valid handshake.
- Drives the register-file write port (WriteReg, WriteData, writeregenable) and stalls upstream while a load is outstanding.
- Supplies same-cycle bypass selects to Decode and keeps a retired-write counter.

---
 rtl/writeback_stage.sv | 149 ++++++++++++++
 tb/tb_writeback_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage and the write side of the register file that Decode
//   reads. It takes the MEM/WB bundle, waits for load data when the result
//   comes from memory, and drives a one-cycle register-file write strobe.
//   It also provides same-cycle bypass selects to Decode and counts the
//   writes it has retired.
//
// Ports
//   Clk, Rst_n          clock; asynchronous active-low reset
//   in_valid            MEM/WB bundle valid (taken only while wb_stall=0)
//   in_regwrite         instruction writes a register
//   in_memtoreg         result comes from data memory
//   in_dest             destination register (already RegDst-muxed)
//   in_alu_result       ALU result
//   mem_rdata_valid     load data strobe from data memory
//   mem_rdata           load data
//   rd_addr1/rd_addr2   Decode read addresses, used for bypass compare
//   wb_stall            upstream must hold its bundle (load outstanding)
//   WriteReg/WriteData  register-file write address / data
//   writeregenable      register-file write enable, one-cycle pulse
//   fwd_sel1/fwd_sel2   Decode takes WriteData instead of ReadData1/2
//   err_timeout         sticky, set when a load is abandoned
//   retired_cnt         count of committed writes, wraps
module writeback_stage #(
  parameter int LOAD_TIMEOUT = 16,  // 1..255
  parameter int CNT_W        = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_valid,
  input  logic             in_regwrite,
  input  logic             in_memtoreg,
  input  logic [4:0]       in_dest,
  input  logic [31:0]      in_alu_result,
  input  logic             mem_rdata_valid,
  input  logic [31:0]      mem_rdata,
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  output logic             wb_stall,
  output logic [4:0]       WriteReg,
  output logic [31:0]      WriteData,
  output logic             writeregenable,
  output logic             fwd_sel1,
  output logic             fwd_sel2,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  // Context of the load waiting for its data.
  typedef struct packed {
    logic       regwrite;
    logic [4:0] dest;
  } ld_ctx_t;

  // Last counter value spent waiting before the load is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t             state_q, state_d;
  ld_ctx_t            ld_q, ld_d;
  logic [7:0]         tmo_q, tmo_d;
  logic [4:0]         wreg_q, wreg_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    tmo_d   = tmo_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;

    // The strobe visible this cycle is the write being committed.
    if (we_q) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        // mem_rdata_valid has no meaning here and is ignored.
        if (in_valid) begin
          if (!in_memtoreg) begin
            wreg_d  = in_dest;
            wdata_d = in_alu_result;
            we_d    = in_regwrite && (in_dest != 5'd0);
          end else begin
            ld_d    = '{regwrite: in_regwrite, dest: in_dest};
            tmo_d   = 8'd0;
            state_d = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        // Data arriving on the last allowed cycle still beats the timeout.
        if (mem_rdata_valid) begin
          wreg_d  = ld_q.dest;
          wdata_d = mem_rdata;
          we_d    = ld_q.regwrite && (ld_q.dest != 5'd0);
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d   = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ld_q    <= '0;
      tmo_q   <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      tmo_q   <= tmo_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_stall       = (state_q == WAIT_LOAD);
  assign WriteReg       = wreg_q;
  assign WriteData      = wdata_q;
  assign writeregenable = we_q;
  assign err_timeout    = err_q;
  assign retired_cnt    = cnt_q;

  // Bypass: the register file commits on the edge that ends the strobe, so
  // a same-cycle read of that register must take WriteData. $0 never bypasses.
  assign fwd_sel1 = we_q && (wreg_q == rd_addr1) && (rd_addr1 != 5'd0);
  assign fwd_sel2 = we_q && (wreg_q == rd_addr2) && (rd_addr2 != 5'd0);

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        in_valid, in_regwrite, in_memtoreg;
  logic [4:0]  in_dest;
  logic [31:0] in_alu_result;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        wb_stall;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        writeregenable, fwd_sel1, fwd_sel2, err_timeout;
  logic [31:0] retired_cnt;

  writeback_stage #(.LOAD_TIMEOUT(4), .CNT_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_dest(in_dest), .in_alu_result(in_alu_result),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wb_stall(wb_stall), .WriteReg(WriteReg), .WriteData(WriteData),
    .writeregenable(writeregenable), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .err_timeout(err_timeout), .retired_cnt(retired_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge Clk) begin
    if (Rst_n && writeregenable) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got reg=%0d data=0x%0h want none", WriteReg, WriteData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (WriteReg !== e.r || WriteData !== e.d) begin
          bad++;
          $display("FAIL write: got reg=%0d data=0x%0h want reg=%0d data=0x%0h",
                   WriteReg, WriteData, e.r, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bundle(input logic rw, input logic m2r, input logic [4:0] d, input logic [31:0] a);
    in_valid = 1'b1; in_regwrite = rw; in_memtoreg = m2r; in_dest = d; in_alu_result = a;
  endtask

  initial begin
    Rst_n = 1'b0;
    in_valid = 0; in_regwrite = 0; in_memtoreg = 0; in_dest = 0; in_alu_result = 0;
    mem_rdata_valid = 0; mem_rdata = 0; rd_addr1 = 0; rd_addr2 = 0;
    tick(); tick();
    chk("rst_stall", {31'd0, wb_stall}, 32'd0);
    chk("rst_wreg", {27'd0, WriteReg}, 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_we", {31'd0, writeregenable}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_cnt", retired_cnt, 32'd0);
    Rst_n = 1'b1;
    tick();

    // ALU write 9 <- 0xD, one-cycle pulse.
    bundle(1, 0, 5'd9, 32'h0000_000D);
    exp_q.push_back('{r: 5'd9, d: 32'hD});
    tick();
    in_valid = 0;
    chk("alu_we", {31'd0, writeregenable}, 32'd1);
    tick();
    chk("alu_pulse_end", {31'd0, writeregenable}, 32'd0);
    chk("alu_hold_wreg", {27'd0, WriteReg}, 32'd9);
    chk("alu_cnt", retired_cnt, 32'd1);

    // Forwarding with WriteReg=10.
    bundle(1, 0, 5'd10, 32'h0000_1234);
    exp_q.push_back('{r: 5'd10, d: 32'h1234});
    tick();
    in_valid = 0; rd_addr1 = 5'd10; rd_addr2 = 5'd11;
    #1;
    chk("fwd1_hit", {31'd0, fwd_sel1}, 32'd1);
    chk("fwd2_miss", {31'd0, fwd_sel2}, 32'd0);
    tick();
    chk("fwd1_after", {31'd0, fwd_sel1}, 32'd0);
    chk("fwd_cnt", retired_cnt, 32'd2);

    // $0 suppression.
    bundle(1, 0, 5'd0, 32'hFFFF_FFFF);
    tick();
    in_valid = 0; rd_addr1 = 5'd0;
    #1;
    chk("r0_we", {31'd0, writeregenable}, 32'd0);
    chk("r0_fwd1", {31'd0, fwd_sel1}, 32'd0);
    chk("r0_wdata", WriteData, 32'hFFFF_FFFF);
    // regwrite=0 also produces no strobe.
    bundle(0, 0, 5'd5, 32'h55);
    tick();
    in_valid = 0;
    chk("norw_we", {31'd0, writeregenable}, 32'd0);
    tick();
    chk("r0_cnt", retired_cnt, 32'd2);

    // Load to 17, data three cycles later; a held bundle must wait.
    bundle(1, 1, 5'd17, 32'hBAD0_0001);
    tick();
    bundle(1, 0, 5'd3, 32'h333);
    chk("ld_stall0", {31'd0, wb_stall}, 32'd1);
    tick();
    chk("ld_stall1", {31'd0, wb_stall}, 32'd1);
    chk("ld_we_wait", {31'd0, writeregenable}, 32'd0);
    tick();
    chk("ld_stall2", {31'd0, wb_stall}, 32'd1);
    mem_rdata_valid = 1; mem_rdata = 32'h500;
    exp_q.push_back('{r: 5'd17, d: 32'h500});
    tick();
    mem_rdata_valid = 0;
    chk("ld_stall_drop", {31'd0, wb_stall}, 32'd0);
    chk("ld_we", {31'd0, writeregenable}, 32'd1);
    exp_q.push_back('{r: 5'd3, d: 32'h333});
    tick();
    in_valid = 0;
    chk("held_we", {31'd0, writeregenable}, 32'd1);
    tick();

    // Data on the last allowed wait cycle wins over the timeout.
    bundle(1, 1, 5'd21, 32'h0);
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    chk("late_stall", {31'd0, wb_stall}, 32'd1);
    mem_rdata_valid = 1; mem_rdata = 32'hABC;
    exp_q.push_back('{r: 5'd21, d: 32'hABC});
    tick();
    mem_rdata_valid = 0;
    chk("late_err", {31'd0, err_timeout}, 32'd0);
    chk("late_stall_drop", {31'd0, wb_stall}, 32'd0);
    tick();

    // Timeout: no data, back to IDLE after 4 waiting cycles.
    bundle(1, 1, 5'd20, 32'h0);
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    chk("tmo_stall3", {31'd0, wb_stall}, 32'd1);
    chk("tmo_err_pre", {31'd0, err_timeout}, 32'd0);
    tick();
    chk("tmo_stall_drop", {31'd0, wb_stall}, 32'd0);
    chk("tmo_err", {31'd0, err_timeout}, 32'd1);
    chk("tmo_we", {31'd0, writeregenable}, 32'd0);
    tick();
    chk("tmo_err_sticky", {31'd0, err_timeout}, 32'd1);
    chk("cnt_5", retired_cnt, 32'd5);

    // Reset in the middle of a load.
    bundle(1, 1, 5'd22, 32'h0);
    tick();
    in_valid = 0;
    tick();
    chk("mid_stall", {31'd0, wb_stall}, 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("mrst_stall", {31'd0, wb_stall}, 32'd0);
    chk("mrst_wreg", {27'd0, WriteReg}, 32'd0);
    chk("mrst_wdata", WriteData, 32'd0);
    chk("mrst_err", {31'd0, err_timeout}, 32'd0);
    chk("mrst_cnt", retired_cnt, 32'd0);
    tick();
    Rst_n = 1'b1;
    mem_rdata_valid = 1; mem_rdata = 32'hDEAD;
    tick();
    mem_rdata_valid = 0;
    chk("mrst_late_we", {31'd0, writeregenable}, 32'd0);
    chk("mrst_late_stall", {31'd0, wb_stall}, 32'd0);
    tick(); tick();
    chk("mrst_late_cnt", retired_cnt, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
